dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter MEM_SCALE, default 27, word-address width of the shared DRAM port.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_oe  input  1  instruction-side refill request, one-cycle pulse.
REQ-005 SHALL have port i_addr  input  MEM_SCALE  instruction refill address, sampled when i_oe=1.
REQ-006 SHALL have port i_rdata  output  32  instruction refill data.
REQ-007 SHALL have port i_valid  output  1  instruction refill done, one-cycle pulse.
REQ-008 SHALL have port d_oe  input  1  data-side request, one-cycle pulse.
REQ-009 SHALL have port d_we  input  1  data request is a write, sampled with d_oe.
REQ-010 SHALL have port d_addr  input  MEM_SCALE  data address, sampled with d_oe.
REQ-011 SHALL have port d_wdata  input  32  write data, sampled with d_oe.
REQ-012 SHALL have port d_wstrb  input  4  byte enables, sampled with d_oe.
REQ-013 SHALL have port d_rdata  output  32  data read result.
REQ-014 SHALL have port d_valid  output  1  data request done (read data or write ack), one-cycle pulse.
REQ-015 SHALL have ports m_oe/m_we (output 1), m_addr (output MEM_SCALE), m_wdata (output 32) and m_wstrb (output 4), forming the DRAM request; m_oe is a one-cycle pulse.
REQ-016 SHALL have ports m_rdata (input 32) and m_valid (input 1), forming the DRAM response; m_valid is a one-cycle pulse per m_oe.
REQ-017 SHALL have port err  output  1  sticky protocol-violation flag.

Function
REQ-018 SHALL keep one pending flag per requester; the flag sets the cycle after an accepted oe pulse, and the request fields latch with it.
REQ-019 SHALL implement states IDLE, BUSY_I and BUSY_D.
REQ-020 SHALL, in IDLE with any pending flag set, assert m_oe combinationally that cycle, drive the winner's latched fields onto m_*, clear the winner's pending flag, and enter BUSY_I or BUSY_D on the next edge.
REQ-021 SHALL give a latency of one cycle from oe pulse to m_oe when IDLE and uncontended; the oe cycle itself never bypasses to m_oe.
REQ-022 SHALL, in BUSY_x, forward m_valid combinationally to x_valid, forward m_rdata to x_rdata, and return to IDLE on the next edge.
REQ-023 SHALL, after m_valid in cycle T, issue the next m_oe no earlier than T+1.
REQ-024 SHALL drive m_we=0 and m_wstrb=0 for instruction grants.
REQ-025 SHALL ignore m_valid in IDLE and set err.
REQ-026 SHALL keep i_valid and d_valid at 0 whenever the corresponding state is not active.
REQ-027 SHALL accept oe from requester x only when x's pending flag is clear and either x is not the owner or x_valid is asserted in the same cycle.
REQ-028 SHALL drop any other oe from x (x_fields unchanged) and set err.
REQ-029 SHALL, when both flags are pending in IDLE, select the winner per REQ-034/REQ-035.
REQ-030 SHALL hold last_grant, updated on every grant.
REQ-031 SHALL hold m_addr, m_wdata and m_wstrb stable at the granted values while BUSY.

Reset
REQ-032 SHALL, while rst_n=0 at a clock edge, enter IDLE, clear both pending flags, set last_grant=D, and clear err.
REQ-033 SHALL keep m_oe, i_valid and d_valid at 0 while rst_n=0, including a reset asserted mid-BUSY; a late m_valid after reset is ignored per REQ-025, and err is set only after reset releases.

Configuration
REQ-034 SHALL, with macro DRAM_ARB_RR_EN defined, grant the requester not equal to last_grant on contention (round-robin).
REQ-035 SHALL, without DRAM_ARB_RR_EN, always grant D on contention (fixed priority; I may starve); last_grant is still maintained.

Verification
REQ-036 SHALL cover: i_oe=1 at cycle 0, i_addr=0x100 -> m_oe=1 at cycle 1 with m_addr=0x100, m_we=0; m_valid at cycle 5 with m_rdata=0xDEADBEEF -> i_valid=1 and i_rdata=0xDEADBEEF at cycle 5.
REQ-037 SHALL cover: i_oe and d_oe (write, 0x40, d_wdata=0x12345678, d_wstrb=0xF) both at cycle 0, fixed priority -> D granted at cycle 1, I granted in the cycle after d_valid.
REQ-038 SHALL cover: DRAM_ARB_RR_EN with both requesters re-requesting each cycle after valid -> grants alternate I,D,I,D; without the macro -> grants are all D.
REQ-039 SHALL cover: second d_oe while D is pending, and m_valid in IDLE -> each sets err=1, second request dropped, one m_oe issued.
REQ-040 SHALL cover: rst_n=0 in BUSY_D for one cycle -> IDLE next cycle, no d_valid, pending clear, err=0, and a following i_oe is granted one cycle later.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-requester (instruction refill / data) arbiter in front of a single DRAM port.
// Contention policy: define DRAM_ARB_RR_EN for round-robin, otherwise D has fixed priority.
module dram_arbiter #(
    parameter int MEM_SCALE = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_oe,
    input  logic [MEM_SCALE-1:0] i_addr,
    output logic [31:0]          i_rdata,
    output logic                 i_valid,
    input  logic                 d_oe,
    input  logic                 d_we,
    input  logic [MEM_SCALE-1:0] d_addr,
    input  logic [31:0]          d_wdata,
    input  logic [3:0]           d_wstrb,
    output logic [31:0]          d_rdata,
    output logic                 d_valid,
    output logic                 m_oe,
    output logic                 m_we,
    output logic [MEM_SCALE-1:0] m_addr,
    output logic [31:0]          m_wdata,
    output logic [3:0]           m_wstrb,
    input  logic [31:0]          m_rdata,
    input  logic                 m_valid,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    typedef struct packed {
        logic                 we;
        logic [MEM_SCALE-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           wstrb;
    } req_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    state_t               state, state_nxt;
    logic                 pend_i, pend_d;
    logic [MEM_SCALE-1:0] i_addr_q;
    req_t                 d_req_q;
    req_t                 gnt_q;
    req_t                 win_req;
    logic                 last_grant;
    logic                 grant, win_d, pick_d;
    logic                 accept_i, accept_d, viol;

`ifdef DRAM_ARB_RR_EN
    assign pick_d = (last_grant == GNT_I);
`else
    // D always wins; last_grant is still tracked so both builds keep the same state.
    assign pick_d = (last_grant == GNT_I) | 1'b1;
`endif

    assign grant   = (state == IDLE) && (pend_i || pend_d);
    assign win_d   = pend_d && (!pend_i || pick_d);
    assign win_req = win_d ? d_req_q
                           : req_t'{we: 1'b0, addr: i_addr_q, wdata: 32'h0, wstrb: 4'h0};

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    always_comb begin
        state_nxt = state;
        m_oe      = 1'b0;
        i_valid   = 1'b0;
        d_valid   = 1'b0;
        // Granted fields stay on the bus for the whole transaction.
        {m_we, m_addr, m_wdata, m_wstrb} = (state == IDLE) ? win_req : gnt_q;
        case (state)
            IDLE: begin
                if (grant) begin
                    m_oe      = rst_n;
                    state_nxt = win_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I: begin
                i_valid = rst_n && m_valid;
                if (m_valid) state_nxt = IDLE;
            end
            BUSY_D: begin
                d_valid = rst_n && m_valid;
                if (m_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The owner may re-request only in the cycle its response returns.
    assign accept_i = i_oe && !pend_i && ((state != BUSY_I) || i_valid);
    assign accept_d = d_oe && !pend_d && ((state != BUSY_D) || d_valid);
    assign viol     = (i_oe && !accept_i) || (d_oe && !accept_d) ||
                      ((state == IDLE) && m_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_i     <= 1'b0;
            pend_d     <= 1'b0;
            last_grant <= GNT_D;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_i)             pend_i <= 1'b1;
            else if (grant && !win_d) pend_i <= 1'b0;
            if (accept_d)             pend_d <= 1'b1;
            else if (grant && win_d)  pend_d <= 1'b0;
            if (grant) last_grant <= win_d;
            if (viol)  err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_i) i_addr_q <= i_addr;
        if (accept_d) d_req_q  <= req_t'{we: d_we, addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
        if (grant)    gnt_q    <= win_req;
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed vector table, contention sequences, randomized run vs a request-level model.
module tb_dram_arbiter;
    localparam int MS = 27;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_oe, d_oe, d_we, m_valid;
    logic [MS-1:0] i_addr, d_addr;
    logic [31:0]   d_wdata, m_rdata;
    logic [3:0]    d_wstrb;
    logic [31:0]   i_rdata, d_rdata, m_wdata;
    logic          i_valid, d_valid, m_oe, m_we, err;
    logic [MS-1:0] m_addr;
    logic [3:0]    m_wstrb;

    always #5 clk = ~clk;

    dram_arbiter #(.MEM_SCALE(MS)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_oe(i_oe), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_oe(d_oe), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_oe(m_oe), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rdata(m_rdata), .m_valid(m_valid), .err(err)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        i_oe = 1'b0; i_addr = '0; d_oe = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_wstrb = '0; m_valid = 1'b0; m_rdata = '0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic rst, io, doe, dwe, mv;
        logic [MS-1:0] ia, da;
        logic [31:0] dwd, mrd;
        logic [3:0] dws;
        logic moe, mwe, iv, dv, er;
        logic [MS-1:0] ma;
        logic [31:0] mwd;
        logic [3:0] mws;
    } vec_t;

    function automatic vec_t mk(input int rst, io, ia, doe, dwe, da, dwd, dws, mv, mrd,
                                moe, ma, mwe, mwd, mws, iv, dv, er);
        vec_t v;
        v.rst = rst[0]; v.io = io[0]; v.ia = ia[MS-1:0]; v.doe = doe[0]; v.dwe = dwe[0];
        v.da = da[MS-1:0]; v.dwd = dwd; v.dws = dws[3:0]; v.mv = mv[0]; v.mrd = mrd;
        v.moe = moe[0]; v.ma = ma[MS-1:0]; v.mwe = mwe[0]; v.mwd = mwd; v.mws = mws[3:0];
        v.iv = iv[0]; v.dv = dv[0]; v.er = er[0];
        return v;
    endfunction

    // Request-level reference: index 0 = I, 1 = D; own = -1 means port free.
    typedef struct packed {
        logic          we;
        logic [MS-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
    } req_t;

    req_t fld[2];
    req_t gnt, exp_req;
    req_t in_req[2];
    bit   pend[2];
    bit   ev[2];
    bit   acc[2];
    bit   oe_in[2];
    int   own, last, win, cd;
    bit   merr, exp_moe;

    task automatic model_reset();
        pend[0] = 1'b0; pend[1] = 1'b0; own = -1; last = 1; merr = 1'b0; cd = 0;
    endtask

    vec_t tbl[26];
    logic [MS-1:0] first_a, second_a, exp_a;
    logic [31:0]   r;

    initial begin
        tbl[0]  = mk(1,1,'h100,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0);
        tbl[1]  = mk(1,0,0,0,0,0,0,0,0,0,                1,'h100,0,0,0,0,0,0);
        tbl[2]  = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);
        tbl[3]  = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);
        tbl[4]  = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);
        tbl[5]  = mk(1,0,0,0,0,0,0,0,1,'hDEADBEEF,       0,0,0,0,0,1,0,0);
        tbl[6]  = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);
        tbl[7]  = mk(0,0,0,0,0,0,0,0,1,'h5A5A,           0,0,0,0,0,0,0,0);
        tbl[8]  = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);
        tbl[9]  = mk(1,0,0,0,0,0,0,0,1,'h1,              0,0,0,0,0,0,0,0);
        tbl[10] = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[11] = mk(0,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[12] = mk(1,0,0,1,0,'h55,0,0,0,0,             0,0,0,0,0,0,0,0);
        tbl[13] = mk(1,0,0,1,0,'h66,'h99,'h3,0,0,        1,'h55,0,0,0,0,0,0);
        tbl[14] = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[15] = mk(1,0,0,0,0,0,0,0,1,'h11,             0,0,0,0,0,0,1,1);
        tbl[16] = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[17] = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[18] = mk(0,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,1);
        tbl[19] = mk(1,0,0,1,1,'h40,'h12345678,'hF,0,0,  0,0,0,0,0,0,0,0);
        tbl[20] = mk(1,0,0,0,0,0,0,0,0,0,                1,'h40,1,'h12345678,'hF,0,0,0);
        tbl[21] = mk(0,0,0,0,0,0,0,0,1,'h77,             0,0,0,0,0,0,0,0);
        tbl[22] = mk(1,1,'h200,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,0);
        tbl[23] = mk(1,0,0,0,0,0,0,0,0,0,                1,'h200,0,0,0,0,0,0);
        tbl[24] = mk(1,0,0,0,0,0,0,0,1,'hCAFEF00D,       0,0,0,0,0,1,0,0);
        tbl[25] = mk(1,0,0,0,0,0,0,0,0,0,                0,0,0,0,0,0,0,0);

        idle_in();
        rst_n = 1'b0;
        next_cyc();
        next_cyc();
        #2;
        chk("reset_err", 64'(err), 64'(0));
        chk("reset_m_oe", 64'(m_oe), 64'(0));
        chk("reset_valid", 64'({i_valid, d_valid}), 64'(0));
        rst_n = 1'b1;

        for (int k = 0; k < 26; k++) begin
            rst_n = tbl[k].rst; i_oe = tbl[k].io; i_addr = tbl[k].ia;
            d_oe = tbl[k].doe; d_we = tbl[k].dwe; d_addr = tbl[k].da;
            d_wdata = tbl[k].dwd; d_wstrb = tbl[k].dws;
            m_valid = tbl[k].mv; m_rdata = tbl[k].mrd;
            #2;
            chk($sformatf("tbl%0d_m_oe", k), 64'(m_oe), 64'(tbl[k].moe));
            chk($sformatf("tbl%0d_i_valid", k), 64'(i_valid), 64'(tbl[k].iv));
            chk($sformatf("tbl%0d_d_valid", k), 64'(d_valid), 64'(tbl[k].dv));
            chk($sformatf("tbl%0d_err", k), 64'(err), 64'(tbl[k].er));
            if (tbl[k].moe) begin
                chk($sformatf("tbl%0d_m_addr", k), 64'(m_addr), 64'(tbl[k].ma));
                chk($sformatf("tbl%0d_m_we", k), 64'(m_we), 64'(tbl[k].mwe));
                chk($sformatf("tbl%0d_m_wstrb", k), 64'(m_wstrb), 64'(tbl[k].mws));
                if (tbl[k].mwe) chk($sformatf("tbl%0d_m_wdata", k), 64'(m_wdata), 64'(tbl[k].mwd));
            end
            if (tbl[k].iv) chk($sformatf("tbl%0d_i_rdata", k), 64'(i_rdata), 64'(tbl[k].mrd));
            if (tbl[k].dv) chk($sformatf("tbl%0d_d_rdata", k), 64'(d_rdata), 64'(tbl[k].mrd));
            next_cyc();
        end

        // Simultaneous I read and D write after reset (last grant = D).
        do_reset();
`ifdef DRAM_ARB_RR_EN
        first_a = MS'('h100); second_a = MS'('h40);
`else
        first_a = MS'('h40);  second_a = MS'('h100);
`endif
        i_oe = 1'b1; i_addr = MS'('h100);
        d_oe = 1'b1; d_we = 1'b1; d_addr = MS'('h40); d_wdata = 32'h12345678; d_wstrb = 4'hF;
        #2; chk("cont_c0_m_oe", 64'(m_oe), 64'(0));
        next_cyc(); idle_in();
        #2; chk("cont_c1_m_oe", 64'(m_oe), 64'(1));
        chk("cont_c1_addr", 64'(m_addr), 64'(first_a));
        chk("cont_c1_we", 64'(m_we), 64'(first_a == MS'('h40)));
        next_cyc();
        #2; chk("cont_c2_m_oe", 64'(m_oe), 64'(0));
        next_cyc();
        m_valid = 1'b1; m_rdata = 32'hAAAA5555;
        #2; chk("cont_c3_valid", 64'({d_valid, i_valid}),
                64'((first_a == MS'('h40)) ? 2'b10 : 2'b01));
        chk("cont_c3_m_oe", 64'(m_oe), 64'(0));
        next_cyc(); m_valid = 1'b0;
        #2; chk("cont_c4_m_oe", 64'(m_oe), 64'(1));
        chk("cont_c4_addr", 64'(m_addr), 64'(second_a));
        chk("cont_c4_wstrb", 64'(m_wstrb), 64'((second_a == MS'('h40)) ? 4'hF : 4'h0));
        next_cyc();
        m_valid = 1'b1;
        #2; chk("cont_c5_valid", 64'({d_valid, i_valid}),
                64'((second_a == MS'('h40)) ? 2'b10 : 2'b01));
        next_cyc(); idle_in();
        #2; chk("cont_c6_m_oe", 64'(m_oe), 64'(0));
        chk("cont_err", 64'(err), 64'(0));

        // Both keep re-requesting: owner re-issues in its valid cycle, the other stays pending.
        do_reset();
        i_oe = 1'b1; i_addr = MS'('h100); d_oe = 1'b1; d_addr = MS'('h40);
        next_cyc(); idle_in();
        for (int g = 0; g < 8; g++) begin
`ifdef DRAM_ARB_RR_EN
            exp_a = (g % 2 == 0) ? MS'('h100) : MS'('h40);
`else
            exp_a = MS'('h40);
`endif
            #2;
            chk($sformatf("rr_g%0d_m_oe", g), 64'(m_oe), 64'(1));
            chk($sformatf("rr_g%0d_addr", g), 64'(m_addr), 64'(exp_a));
            next_cyc();
            m_valid = 1'b1;
            if (exp_a == MS'('h100)) begin i_oe = 1'b1; i_addr = MS'('h100); end
            else begin d_oe = 1'b1; d_addr = MS'('h40); end
            next_cyc(); idle_in();
        end
        #2; chk("rr_err", 64'(err), 64'(0));

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            i_oe = ($urandom_range(0, 5) == 0);
            r = $urandom; i_addr = r[MS-1:0];
            d_oe = ($urandom_range(0, 5) == 0);
            d_we = $urandom_range(0, 1) == 1;
            r = $urandom; d_addr = r[MS-1:0];
            d_wdata = $urandom;
            r = $urandom; d_wstrb = r[3:0];
            m_valid = (cd == 1) || ($urandom_range(0, 99) == 0);
            if (cd > 0) cd--;
            m_rdata = $urandom;
            #2;

            win = -1;
            if (own < 0 && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) begin
`ifdef DRAM_ARB_RR_EN
                    win = 1 - last;
`else
                    win = 1;
`endif
                end else begin
                    win = pend[1] ? 1 : 0;
                end
            end
            exp_moe = rst_n && (win >= 0);
            for (int x = 0; x < 2; x++) ev[x] = rst_n && (own == x) && m_valid;

            chk("rnd_m_oe", 64'(m_oe), 64'(exp_moe));
            chk("rnd_i_valid", 64'(i_valid), 64'(ev[0]));
            chk("rnd_d_valid", 64'(d_valid), 64'(ev[1]));
            chk("rnd_err", 64'(err), 64'(merr));
            if (rst_n && (win >= 0 || own >= 0)) begin
                exp_req = (win >= 0) ? fld[win] : gnt;
                chk("rnd_m_addr", 64'(m_addr), 64'(exp_req.addr));
                chk("rnd_m_we", 64'(m_we), 64'(exp_req.we));
                chk("rnd_m_wstrb", 64'(m_wstrb), 64'(exp_req.wstrb));
                if (exp_req.we) chk("rnd_m_wdata", 64'(m_wdata), 64'(exp_req.wdata));
            end
            if (ev[0]) chk("rnd_i_rdata", 64'(i_rdata), 64'(m_rdata));
            if (ev[1]) chk("rnd_d_rdata", 64'(d_rdata), 64'(m_rdata));

            if (!rst_n) begin
                pend[0] = 1'b0; pend[1] = 1'b0; own = -1; last = 1; merr = 1'b0;
            end else begin
                in_req[0] = '{1'b0, i_addr, 32'h0, 4'h0};
                in_req[1] = '{d_we, d_addr, d_wdata, d_wstrb};
                oe_in[0] = i_oe; oe_in[1] = d_oe;
                for (int x = 0; x < 2; x++) begin
                    acc[x] = oe_in[x] && !pend[x] && (own != x || ev[x]);
                    if (oe_in[x] && !acc[x]) merr = 1'b1;
                end
                if (m_valid && own < 0) merr = 1'b1;
                if (win >= 0) begin
                    pend[win] = 1'b0; gnt = fld[win]; own = win; last = win;
                end else if (own >= 0 && m_valid) begin
                    own = -1;
                end
                for (int x = 0; x < 2; x++) begin
                    if (acc[x]) begin pend[x] = 1'b1; fld[x] = in_req[x]; end
                end
            end
            if (exp_moe) cd = $urandom_range(1, 4);
            next_cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
